// File: rtl/param_stack_pkg.sv
// Shared opcode encoding and sizing helper for the nanoRisc operand stack.
package nanorisc_stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_DUP     = 3'd4,
        OP_SWAP    = 3'd5,
        OP_CLEAR   = 3'd6
    } stack_op_e;

    // Ceiling log2 that never returns 0, so a derived width is always a legal vector.
    function automatic int safe_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/param_stack_if.sv
// Decode-stage to operand-stack connection: command inputs and combinational read-back.
interface param_stack_if
    import nanorisc_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = safe_clog2(DEPTH + 1);
    localparam int IW = safe_clog2(DEPTH);

    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [IW-1:0]    peek_idx;

    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] peek_data;
    logic             peek_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, op, din, err_clr, peek_idx,
        input  top, next, peek_data, peek_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  en, op, din, err_clr, peek_idx,
        output top, next, peek_data, peek_valid, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with peek, occupancy count and sticky error flags.
module param_stack
    import nanorisc_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
)
(
    input  logic          clk,
    input  logic          reset,
    param_stack_if.slave  bus
);
    localparam int CW = safe_clog2(DEPTH + 1);
    localparam int IW = safe_clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             is_empty, is_full, has_two;
    logic [IW-1:0]    a_push, a_top, a_next, a_peek;
    logic [CW-1:0]    peek_ext;
    logic             peek_ok;
    logic             err_o, err_u;

    // Entry n-1 is the top; addresses are only used when the guarding count test passes.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign has_two  = (count_q > CW'(1));
    assign a_push   = IW'(count_q);
    assign a_top    = IW'(count_q - CW'(1));
    assign a_next   = IW'(count_q - CW'(2));
    assign peek_ext = CW'(bus.peek_idx);
    assign peek_ok  = (peek_ext < count_q);
    assign a_peek   = IW'(count_q - CW'(1) - peek_ext);

    assign bus.top        = is_empty ? '0 : mem_q[a_top];
    assign bus.next       = has_two  ? mem_q[a_next] : '0;
    assign bus.peek_data  = peek_ok  ? mem_q[a_peek] : '0;
    assign bus.peek_valid = peek_ok;
    assign bus.count      = count_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        err_o   = 1'b0;
        err_u   = 1'b0;
        if (bus.en) begin
            case (stack_op_e'(bus.op))
                OP_PUSH: begin
                    if (!is_full) begin
                        mem_d[a_push] = bus.din;
                        count_d       = count_q + CW'(1);
                    end else begin
                        err_o = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!is_empty) count_d = count_q - CW'(1);
                    else           err_u   = 1'b1;
                end
                OP_REPLACE: begin
                    if (!is_empty) mem_d[a_top] = bus.din;
                    else           err_u        = 1'b1;
                end
                OP_DUP: begin
                    if (is_empty) begin
                        err_u = 1'b1;
                    end else if (is_full) begin
                        err_o = 1'b1;
                    end else begin
                        mem_d[a_push] = mem_q[a_top];
                        count_d       = count_q + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        err_u = 1'b1;
                    end else begin
                        mem_d[a_top]  = mem_q[a_next];
                        mem_d[a_next] = mem_q[a_top];
                    end
                end
                OP_CLEAR: count_d = '0;
                default: ;
            endcase
        end
        // A fresh error outranks a simultaneous clear.
        ovf_d = (ovf_q & ~bus.err_clr) | err_o;
        unf_d = (unf_q & ~bus.err_clr) | err_u;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never reset; every read is masked by count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

endmodule
